// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues one word read per cycle
// and writes returned words into the cache, then the tag on the last word.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the fill
// at the missing word instead of word 0.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] cache_addr
);

    localparam int IW = $clog2(BLOCK_WORDS);
    localparam int CW = IW + 1;
    localparam int OW = IW + 1;
    localparam logic [15:0] BASE_MASK = ~16'((1 << OW) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [15:0]     base_q;
    logic [IW-1:0]   start_q;
    logic [IW-1:0]   start_d;
    logic [CW-1:0]   iss_q;
    logic [CW-1:0]   ret_q;
    logic [IW-1:0]   iss_idx;
    logic [IW-1:0]   ret_idx;
    logic            iss_open;
    logic            last_ret;

    // Byte offset of a 16-bit word inside the block.
    function automatic logic [15:0] word_off(input logic [IW-1:0] idx);
        return {{(16 - OW){1'b0}}, idx, 1'b0};
    endfunction

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign start_d = miss_address[OW-1:1];
`else
    assign start_d = '0;
`endif

    // Word indices wrap inside the block by IW-bit truncation.
    assign iss_idx  = start_q + iss_q[IW-1:0];
    assign ret_idx  = start_q + ret_q[IW-1:0];
    assign iss_open = (iss_q < CW'(BLOCK_WORDS));
    assign last_ret = (ret_q == CW'(BLOCK_WORDS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Block base, start offset and issue/return counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            start_q <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_q  <= miss_address & BASE_MASK;
                        start_q <= start_d;
                        iss_q   <= '0;
                        ret_q   <= '0;
                    end
                end
                FILL: begin
                    if (iss_open) begin
                        iss_q <= iss_q + CW'(1);
                    end
                    if (memory_data_valid) begin
                        if (last_ret) begin
                            iss_q <= '0;
                            ret_q <= '0;
                        end else begin
                            ret_q <= ret_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Next-state: leave IDLE on a miss, leave FILL on the last returned word.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (memory_data_valid && last_ret) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    // Outputs: requests, data/tag writes and the cache address; all low in reset.
    always_comb begin
        fsm_busy         = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_addr       = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    fsm_busy = miss_detected;
                end
                FILL: begin
                    fsm_busy   = 1'b1;
                    cache_addr = base_q;
                    if (iss_open) begin
                        memory_read    = 1'b1;
                        memory_address = base_q | word_off(iss_idx);
                    end
                    if (memory_data_valid) begin
                        write_data_array = 1'b1;
                        write_tag_array  = last_ret;
                        cache_addr       = base_q | word_off(ret_idx)
                                         | {15'b0, last_ret};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: queue-based fill model checked
// every cycle, plus literal request/write sequences for the named scenarios.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_addr;

    int vectors;
    int miscompares;

    // model state
    bit          in_fill;
    logic [15:0] fill_base;
    logic [15:0] req_q[$];
    logic [15:0] wr_q[$];

    // observations of the DUT for literal checks
    logic [15:0] obs_req[$];
    logic [15:0] obs_wr[$];
    int          n_tags;
    int          busy_cyc;

    cache_fill_fsm #(.BLOCK_WORDS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_addr        (cache_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model: a fill is a list of 8 requests and 8 writes.
    always @(negedge clk) begin
        logic        e_busy, e_rd, e_wd, e_wt;
        logic [15:0] e_ma, e_ca, b;
        int          s;
        e_busy = 0; e_rd = 0; e_wd = 0; e_wt = 0;
        e_ma = '0; e_ca = '0;
        if (rst) begin
            in_fill = 0;
            req_q.delete();
            wr_q.delete();
        end else if (!in_fill) begin
            e_busy = miss_detected;
            if (miss_detected) begin
                b = miss_address & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                s = int'(miss_address[3:1]);
`else
                s = 0;
`endif
                for (int n = 0; n < 8; n++) begin
                    req_q.push_back(16'(b + 2 * ((s + n) % 8)));
                    wr_q.push_back(16'(b + 2 * ((s + n) % 8)));
                end
                fill_base = b;
                in_fill = 1;
            end
        end else begin
            e_busy = 1;
            e_ca = fill_base;
            if (req_q.size() > 0) begin
                e_rd = 1;
                e_ma = req_q.pop_front();
            end
            if (memory_data_valid) begin
                e_wd = 1;
                e_ca = wr_q.pop_front();
                if (wr_q.size() == 0) begin
                    e_wt = 1;
                    e_ca = e_ca | 16'h0001;
                    in_fill = 0;
                    req_q.delete();
                end
            end
        end
        chk("busy", 16'(fsm_busy), 16'(e_busy));
        chk("mem_read", 16'(memory_read), 16'(e_rd));
        if (e_rd) chk("mem_addr", memory_address, e_ma);
        chk("wr_data", 16'(write_data_array), 16'(e_wd));
        chk("wr_tag", 16'(write_tag_array), 16'(e_wt));
        chk("cache_addr", cache_addr, e_ca);
        if (memory_read) obs_req.push_back(memory_address);
        if (write_data_array) obs_wr.push_back(cache_addr);
        if (write_tag_array) n_tags++;
        if (fsm_busy) busy_cyc++;
    end

    task automatic step(input logic m, input logic [15:0] a, input logic v);
        miss_detected = m;
        miss_address = a;
        memory_data_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_req.delete();
        obs_wr.delete();
        n_tags = 0;
        busy_cyc = 0;
    endtask

    // Twelve fill cycles with memory latency 4 (valid on cycles 4..11).
    task automatic lat4(input logic m, input logic [15:0] a);
        for (int n = 0; n < 12; n++) step(m, a, n >= 4);
    endtask

    task automatic chk_seq(input string nm, input int off,
                           input logic [15:0] q[$], input logic [15:0] e[8]);
        for (int i = 0; i < 8; i++) begin
            chk(nm, (off + i < q.size()) ? q[off + i] : 16'hDEAD, e[i]);
        end
    endtask

    logic [15:0] e_req[8];
    logic [15:0] e_wr[8];
    logic [15:0] pat;
    logic [17:0] gap_pat;

    initial begin
        vectors = 0;
        miscompares = 0;
        in_fill = 0;
        clear_obs();
        rst = 1;
        miss_detected = 0;
        miss_address = 0;
        memory_data_valid = 0;
        #2;
        miss_detected = 1;
        memory_data_valid = 1;
        #1;
        chk("rst_busy", 16'(fsm_busy), 16'd0);
        chk("rst_read", 16'(memory_read), 16'd0);
        chk("rst_wd", 16'(write_data_array), 16'd0);
        chk("rst_wt", 16'(write_tag_array), 16'd0);
        chk("rst_caddr", cache_addr, 16'd0);
        @(posedge clk); #1;
        rst = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        // miss at 0x1236, latency 4
        clear_obs();
        step(1, 16'h1236, 0);
        lat4(0, 16'h1236);
        step(0, 0, 0);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        e_req = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                  16'h123E, 16'h1230, 16'h1232, 16'h1234};
        e_wr = e_req;
        e_wr[7] = 16'h1235;
`else
        for (int i = 0; i < 8; i++) e_req[i] = 16'(16'h1230 + 2 * i);
        e_wr = e_req;
        e_wr[7] = 16'h123F;
`endif
        chk_seq("t1_req", 0, obs_req, e_req);
        chk_seq("t1_wr", 0, obs_wr, e_wr);
        chk("t1_nreq", 16'(obs_req.size()), 16'd8);
        chk("t1_tags", 16'(n_tags), 16'd1);
        chk("t1_busy_cyc", 16'(busy_cyc), 16'd13);

        // irregular returns, gaps of 0-3 cycles
        clear_obs();
        gap_pat = 18'b10_1001_0110_0011_0010;
        step(1, 16'h2468, 0);
        for (int n = 0; n < 18; n++) step(0, 16'h2468, gap_pat[n]);
        chk("t2_busy_after", 16'(fsm_busy), 16'd0);
        step(0, 0, 0);
        chk("t2_writes", 16'(obs_wr.size()), 16'd8);
        chk("t2_tags", 16'(n_tags), 16'd1);
        chk("t2_busy_cyc", 16'(busy_cyc), 16'd19);

        // reset after the 3rd returned word
        clear_obs();
        step(1, 16'h3000, 0);
        for (int n = 0; n < 6; n++) step(0, 16'h3000, n >= 3);
        memory_data_valid = 1;
        rst = 1;
        miss_detected = 1;
        #1;
        chk("t3_rst_busy", 16'(fsm_busy), 16'd0);
        chk("t3_rst_read", 16'(memory_read), 16'd0);
        chk("t3_rst_wd", 16'(write_data_array), 16'd0);
        chk("t3_rst_caddr", cache_addr, 16'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int n = 0; n < 3; n++) step(0, 16'h3000, 1);
        step(0, 0, 0);
        chk("t3_writes", 16'(obs_wr.size()), 16'd3);
        chk("t3_tags", 16'(n_tags), 16'd0);
        clear_obs();
        step(1, 16'h4010, 0);
        lat4(0, 16'h4010);
        step(0, 0, 0);
        chk("t3b_writes", 16'(obs_wr.size()), 16'd8);
        chk("t3b_tags", 16'(n_tags), 16'd1);
        chk("t3b_first_req", obs_req.size() > 0 ? obs_req[0] : 16'hDEAD,
            16'h4010);

        // valid in IDLE ignored; miss toggling during FILL ignored
        clear_obs();
        for (int n = 0; n < 3; n++) step(0, 16'h5552, 1);
        chk("t4_idle_wr", 16'(obs_wr.size()), 16'd0);
        step(1, 16'h5552, 0);
        for (int n = 0; n < 12; n++) begin
            step((n < 10) && n[0], 16'h9990, n >= 4);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("t4_nreq", 16'(obs_req.size()), 16'd8);
        chk("t4_tags", 16'(n_tags), 16'd1);
        pat = 16'h5550;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        pat = 16'h5552;
`endif
        chk("t4_first_wr", obs_wr.size() > 0 ? obs_wr[0] : 16'hDEAD, pat);

        // back-to-back misses 0x0040 then 0xFFF0
        clear_obs();
        step(1, 16'h0040, 0);
        lat4(1, 16'hFFF0);
        step(1, 16'hFFF0, 0);
        lat4(0, 16'hFFF0);
        step(0, 0, 0);
        for (int i = 0; i < 8; i++) e_req[i] = 16'(16'h0040 + 2 * i);
        chk_seq("t5_req_a", 0, obs_req, e_req);
        for (int i = 0; i < 8; i++) e_req[i] = 16'(16'hFFF0 + 2 * i);
        chk_seq("t5_req_b", 8, obs_req, e_req);
        chk("t5_last_wr", obs_wr.size() == 16 ? obs_wr[15] : 16'hDEAD,
            16'hFFFF);
        chk("t5_tags", 16'(n_tags), 16'd2);
        chk("t5_busy_cyc", 16'(busy_cyc), 16'd26);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter BLOCK_WORDS, default 8, number of 16-bit words per cache block; SHALL be a power of two, and 8 is the only value used with the current cache.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 miss_detected  input  1  cache_miss from the cache for the current access.
REQ-005 miss_address  input  16  byte address of the missing access.
REQ-006 memory_data_valid  input  1  main memory is returning one word this cycle.
REQ-007 fsm_busy  output  1  stall request to the pipeline.
REQ-008 memory_read  output  1  read request to main memory this cycle.
REQ-009 memory_address  output  16  word-aligned address of the read request.
REQ-010 write_data_array  output  1  write the returned word into the cache data array.
REQ-011 write_tag_array  output  1  write tag and valid into the cache metadata array.
REQ-012 cache_addr  output  16  address driven to the cache's memAddr during the fill.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and FILL.
REQ-014 In IDLE, when miss_detected=1, the block SHALL latch base={miss_address[15:4],4'b0} and the start offset, and SHALL enter FILL on the next edge.
REQ-015 fsm_busy SHALL equal (state==FILL) | (state==IDLE & miss_detected), combinationally, so the pipeline stalls in the miss cycle.
REQ-016 In FILL, the issue counter SHALL advance one word per cycle for exactly BLOCK_WORDS cycles, starting at the first FILL cycle.
REQ-017 For each of those BLOCK_WORDS cycles, memory_read SHALL be 1 and memory_address SHALL be base + 2*word_index, with bit 0 = 0.
REQ-018 After the last request, memory_read SHALL be 0 until the next fill.
REQ-019 The block SHALL count returned words independently of issued words; memory latency is not assumed, and only arrival order is used.
REQ-020 When memory_data_valid=1 in FILL, write_data_array SHALL be 1 in that cycle.
REQ-021 In that cycle, cache_addr SHALL be base + 2*word_index of the k-th returned word, and the return counter SHALL increment.
REQ-022 On the BLOCK_WORDS-th returned word, write_tag_array SHALL also be 1 in the same cycle.
REQ-023 After the BLOCK_WORDS-th returned word, the FSM SHALL return to IDLE on the next edge and both counters SHALL clear.
REQ-024 cache_addr[0] SHALL equal write_tag_array; the cache takes its valid bit from memAddr[0].
REQ-025 When no data write occurs in FILL, cache_addr SHALL be base with bit 0 = 0; in IDLE, cache_addr SHALL be 0.
REQ-026 word_index arithmetic SHALL be modulo BLOCK_WORDS, so the address never leaves the block.
REQ-027 In IDLE, memory_data_valid SHALL be ignored: no write and no count.
REQ-028 In FILL, miss_detected and miss_address SHALL be ignored; base is held.
REQ-029 The return counter SHALL count only valid words received in FILL, including words arriving while requests are still being issued.
REQ-030 miss_detected=1 in the same cycle the FSM returns to IDLE SHALL start a new fill on the following IDLE cycle only.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE, counters and base SHALL be 0, and memory_read, write_data_array, write_tag_array and cache_addr SHALL be 0.
REQ-032 While rst=1, fsm_busy SHALL be 0 regardless of miss_detected.
REQ-033 rst asserted mid-fill SHALL abort immediately and write no tag; memory words in flight after release SHALL be ignored in IDLE.

Configuration
REQ-034 Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN SHALL select the start offset of the fill.
REQ-035 Without CACHE_FILL_CRITICAL_WORD_FIRST_EN, the start offset SHALL be 0, and words SHALL be requested and written in order 0..BLOCK_WORDS-1.
REQ-036 With CACHE_FILL_CRITICAL_WORD_FIRST_EN, the start offset SHALL be miss_address[3:1]; word_index = (start + n) mod BLOCK_WORDS, applied identically to requests and returned writes.

Verification
REQ-037 Macro off, miss at 0x1236, memory latency 4 -> memory_address 0x1230,0x1232,...,0x123E on 8 consecutive cycles; 8 data writes at cache_addr 0x1230..0x123E; write_tag_array with cache_addr 0x123F on the 8th; fsm_busy high for 12 cycles plus the miss cycle.
REQ-038 Macro on, miss at 0x1236 -> request order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; tag write at cache_addr 0x1235.
REQ-039 Irregular returns (valid gaps of 0-3 cycles) -> exactly 8 data writes; the tag write coincides with the 8th valid; then IDLE.
REQ-040 rst pulsed after the 3rd returned word -> outputs 0 asynchronously; no tag write; later stray valids produce no writes; the next miss fills correctly.
REQ-041 memory_data_valid=1 in IDLE, and miss_detected toggled during FILL -> no writes, base unchanged, exactly one fill.
REQ-042 Back-to-back misses 0x0040 then 0xFFF0 -> second fill starts after one IDLE cycle, and requests 0xFFF0..0xFFFE do not wrap past 0xFFFE.
